// File: rtl/lzw_pkg.sv
// Shared LZW types and constants for the encoder, the CAM dictionary and the bit packer.
package lzw_pkg;

    localparam int unsigned CHAR_WIDTH = 8;
    localparam int unsigned NUM_LIT    = 2 ** CHAR_WIDTH;
    localparam int unsigned NUM_CELL   = 16;
    localparam int unsigned CODE_WIDTH = 9;
    localparam int unsigned KEY_WIDTH  = CODE_WIDTH + CHAR_WIDTH;
    localparam int unsigned IDX_WIDTH  = $clog2(NUM_CELL);

    typedef logic [CHAR_WIDTH-1:0] char_t;
    typedef logic [CODE_WIDTH-1:0] code_t;
    typedef logic [KEY_WIDTH-1:0]  key_t;
    typedef logic [IDX_WIDTH-1:0]  idx_t;

    typedef logic [2:0] state_t;
    localparam state_t S_IDLE      = 3'd0;
    localparam state_t S_PREFIX    = 3'd1;
    localparam state_t S_LOOKUP    = 3'd2;
    localparam state_t S_EMIT      = 3'd3;
    localparam state_t S_EMIT_TAIL = 3'd4;

    // Dictionary entries are numbered after the literal codes.
    function automatic code_t dict_code(input idx_t idx);
        return code_t'(NUM_LIT) + code_t'(idx);
    endfunction

endpackage

// File: rtl/lzw_out_reg.sv
// One-entry valid/ready holding register for the emitted code stream.
module lzw_out_reg
    import lzw_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  i_load,
    input  code_t i_code,
    input  logic  i_last,
    input  logic  i_ready,
    output logic  o_valid,
    output code_t o_code,
    output logic  o_last,
    output logic  o_free_c
);

    assign o_free_c = ~o_valid | i_ready;

    // Payload only changes on a load, so it holds while stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_valid <= 1'b0;
            o_code  <= '0;
            o_last  <= 1'b0;
        end else if (i_load) begin
            o_valid <= 1'b1;
            o_code  <= i_code;
            o_last  <= i_last;
        end else if (i_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/lzw_encoder_ctrl.sv
// LZW encoder control: builds {prefix,char} CAM keys and emits prefix codes on misses.
module lzw_encoder_ctrl
    import lzw_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  in_valid,
    output logic  in_ready,
    input  char_t in_data,
    input  logic  in_last,
    output logic  cam_en,
    output key_t  cam_key,
    input  logic  cam_hit,
    input  idx_t  cam_idx,
    input  logic  cam_full,
    output logic  code_valid,
    input  logic  code_ready,
    output code_t code_data,
    output logic  code_last
);

    state_t r_state, w_state_nxt;
    state_t r_ret, w_ret_nxt;
    code_t  r_prefix, w_prefix_nxt;
    code_t  r_pend, w_pend_nxt;
    char_t  r_char, w_char_nxt;
    logic   r_last, w_last_nxt;
    logic   r_pend_last, w_pend_last_nxt;
    logic   w_in_fire;
    logic   w_slot_free;
    logic   w_load;
    code_t  w_hit_code;
    logic   w_unused_cam_full;

    // A full dictionary only suppresses inserts inside the CAM; the code stream is unaffected.
    assign w_unused_cam_full = cam_full;

    assign in_ready   = rst & ((r_state == S_IDLE) | (r_state == S_PREFIX));
    assign w_in_fire  = in_valid & in_ready;
    assign cam_en     = w_in_fire & (r_state == S_PREFIX);
    assign cam_key    = {r_prefix, in_data};
    assign w_hit_code = dict_code(cam_idx);

    always_comb begin
        w_state_nxt     = r_state;
        w_ret_nxt       = r_ret;
        w_prefix_nxt    = r_prefix;
        w_pend_nxt      = r_pend;
        w_char_nxt      = r_char;
        w_last_nxt      = r_last;
        w_pend_last_nxt = r_pend_last;
        w_load          = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_in_fire) begin
                    w_prefix_nxt = code_t'(in_data);
                    if (in_last) begin
                        w_pend_nxt      = code_t'(in_data);
                        w_pend_last_nxt = 1'b1;
                        w_state_nxt     = S_EMIT;
                    end else begin
                        w_state_nxt = S_PREFIX;
                    end
                end
            end
            S_PREFIX: begin
                if (w_in_fire) begin
                    w_char_nxt  = in_data;
                    w_last_nxt  = in_last;
                    w_state_nxt = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (cam_hit) begin
                    w_prefix_nxt = w_hit_code;
                    if (r_last) begin
                        w_pend_nxt      = w_hit_code;
                        w_pend_last_nxt = 1'b1;
                        w_state_nxt     = S_EMIT;
                    end else begin
                        w_state_nxt = S_PREFIX;
                    end
                end else begin
                    w_pend_nxt      = r_prefix;
                    w_pend_last_nxt = 1'b0;
                    w_prefix_nxt    = code_t'(r_char);
                    w_ret_nxt       = r_last ? S_EMIT_TAIL : S_PREFIX;
                    w_state_nxt     = S_EMIT;
                end
            end
            S_EMIT: begin
                if (w_slot_free) begin
                    w_load      = 1'b1;
                    w_state_nxt = r_pend_last ? S_IDLE : r_ret;
                end
            end
            S_EMIT_TAIL: begin
                w_pend_nxt      = r_prefix;
                w_pend_last_nxt = 1'b1;
                w_state_nxt     = S_EMIT;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_ret       <= S_IDLE;
            r_prefix    <= '0;
            r_pend      <= '0;
            r_char      <= '0;
            r_last      <= 1'b0;
            r_pend_last <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ret       <= w_ret_nxt;
            r_prefix    <= w_prefix_nxt;
            r_pend      <= w_pend_nxt;
            r_char      <= w_char_nxt;
            r_last      <= w_last_nxt;
            r_pend_last <= w_pend_last_nxt;
        end
    end

    lzw_out_reg u_out_reg (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_code   (r_pend),
        .i_last   (r_pend_last),
        .i_ready  (code_ready),
        .o_valid  (code_valid),
        .o_code   (code_data),
        .o_last   (code_last),
        .o_free_c (w_slot_free)
    );

endmodule

// File: tb/tb_lzw_encoder_ctrl.sv
// Directed and randomised checks of lzw_encoder_ctrl against a behavioural CAM and LZW reference.
module tb_lzw_encoder_ctrl;
    import lzw_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'h00;
    logic        in_last = 1'b0;
    logic        cam_en;
    logic [16:0] cam_key;
    logic        cam_hit;
    logic [3:0]  cam_idx;
    logic        cam_full;
    logic        code_valid;
    logic        code_ready = 1'b1;
    logic [8:0]  code_data;
    logic        code_last;

    int n_checks = 0;
    int n_errors = 0;
    int rdy_mode = 0;
    bit throttle = 1'b0;
    int cam_pulses = 0;
    logic [9:0] rx[$];

    lzw_encoder_ctrl dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .cam_en(cam_en), .cam_key(cam_key), .cam_hit(cam_hit), .cam_idx(cam_idx), .cam_full(cam_full),
        .code_valid(code_valid), .code_ready(code_ready), .code_data(code_data), .code_last(code_last)
    );

    always #5 clk = ~clk;

    // Behavioural CAM: result one cycle after the search, insert on miss while not full.
    logic [16:0] cam_keys[16];
    int cam_cnt = 0;
    assign cam_full = (cam_cnt == 16);

    function automatic int cam_search(input logic [16:0] key);
        for (int j = 0; j < 16; j++)
            if (j < cam_cnt && cam_keys[j] == key) return j;
        return -1;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            cam_cnt <= 0;
            cam_hit <= 1'b0;
            cam_idx <= 4'd0;
        end else if (cam_en) begin
            if (cam_search(cam_key) >= 0) begin
                cam_hit <= 1'b1;
                cam_idx <= 4'(cam_search(cam_key));
            end else begin
                cam_hit <= 1'b0;
                cam_idx <= 4'(cam_cnt);
                if (cam_cnt < 16) begin
                    cam_keys[cam_cnt] <= cam_key;
                    cam_cnt <= cam_cnt + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cam_en) cam_pulses++;
        if (rst && code_valid && code_ready) rx.push_back({code_last, code_data});
    end

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       code_ready = 1'b1;
            1:       code_ready = 1'($urandom_range(0, 1));
            default: code_ready = 1'b0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rx.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        int n = 0;
        if (throttle) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        in_data = b;
        in_last = last;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 500) begin
            n++;
            @(negedge clk);
        end
        if (n >= 500) check("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic send_stream(input logic [7:0] b[$]);
        for (int i = 0; i < b.size(); i++) send_byte(b[i], i == b.size() - 1);
    endtask

    task automatic expect_codes(input string tag, input logic [9:0] want[$]);
        int n = 0;
        while (rx.size() < want.size() && n < 3000) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        check({tag, " count"}, 32'(rx.size()), 32'(want.size()));
        for (int i = 0; i < want.size(); i++) begin
            if (i < rx.size()) begin
                check($sformatf("%s code%0d", tag, i), 32'(rx[i][8:0]), 32'(want[i][8:0]));
                check($sformatf("%s last%0d", tag, i), 32'(rx[i][9]), 32'(want[i][9]));
            end
        end
        rx.delete();
    endtask

    // Reference LZW with a 16-entry dictionary searched in insertion order.
    function automatic void lzw_model(input logic [7:0] b[$], output logic [9:0] want[$]);
        logic [16:0] d[$];
        logic [8:0]  w;
        int          f;
        want.delete();
        w = 9'(b[0]);
        for (int i = 1; i < b.size(); i++) begin
            f = -1;
            for (int j = d.size() - 1; j >= 0; j--)
                if (d[j] == {w, b[i]}) f = j;
            if (f >= 0) begin
                w = 9'(256 + f);
            end else begin
                want.push_back({1'b0, w});
                if (d.size() < 16) d.push_back({w, b[i]});
                w = 9'(b[i]);
            end
        end
        want.push_back({1'b1, w});
    endfunction

    logic [7:0] bytes[$];
    logic [9:0] want_q[$];
    int         pulses0;
    logic [8:0] held;
    bit         have;

    initial begin
        // Reset values while rst is held low
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst in_ready", 32'(in_ready), 32'd0);
        check("rst code_valid", 32'(code_valid), 32'd0);
        check("rst code_data", 32'(code_data), 32'd0);
        check("rst code_last", 32'(code_last), 32'd0);
        check("rst cam_en", 32'(cam_en), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // ABAB: idx0 allocation then hit on the final pair
        pulses0 = cam_pulses;
        bytes = '{8'h41, 8'h42, 8'h41, 8'h42};
        send_stream(bytes);
        want_q = '{10'h041, 10'h042, 10'h300};
        expect_codes("abab", want_q);
        check("abab cam_en pulses", 32'(cam_pulses - pulses0), 32'd3);

        // Single byte stream never touches the CAM
        do_reset();
        pulses0 = cam_pulses;
        bytes = '{8'h5A};
        send_stream(bytes);
        want_q = '{10'h25A};
        expect_codes("single", want_q);
        check("single cam_en pulses", 32'(cam_pulses - pulses0), 32'd0);

        // AAAA with a 10-cycle downstream stall after the first code
        do_reset();
        bytes = '{8'h41, 8'h41, 8'h41, 8'h41};
        fork
            send_stream(bytes);
            begin
                int n = 0;
                @(negedge clk);
                while (!(code_valid && code_ready) && n < 200) begin
                    n++;
                    @(negedge clk);
                end
                check("stall first code seen", 32'(n < 200), 32'd1);
                @(posedge clk);
                rdy_mode = 2;
                have = 1'b0;
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    if (code_valid) begin
                        if (!have) begin
                            held = code_data;
                            have = 1'b1;
                        end else begin
                            check("stall data stable", 32'(code_data), 32'(held));
                        end
                    end
                end
                check("stall in_ready", 32'(in_ready), 32'd0);
                check("stall code_valid", 32'(code_valid), 32'd1);
                check("stall code_data", 32'(code_data), 32'h100);
                @(posedge clk);
                rdy_mode = 0;
            end
        join
        want_q = '{10'h041, 10'h100, 10'h241};
        expect_codes("aaaa", want_q);

        // Fill the dictionary, then a repeated pair keeps missing
        do_reset();
        bytes.delete();
        for (int i = 0; i < 18; i++) bytes.push_back(8'(i));
        bytes.push_back(8'h10);
        bytes.push_back(8'h11);
        send_stream(bytes);
        want_q.delete();
        for (int i = 0; i < 18; i++) want_q.push_back(10'(i));
        want_q.push_back(10'h010);
        want_q.push_back(10'h211);
        expect_codes("full", want_q);

        // Reset asserted while in S_LOOKUP with a code held in the output slot
        do_reset();
        rdy_mode = 2;
        @(posedge clk);
        #1;
        send_byte(8'h41, 1'b0);
        send_byte(8'h42, 1'b0);
        send_byte(8'h43, 1'b0);
        check("pre-rst code_valid", 32'(code_valid), 32'd1);
        check("pre-rst code_data", 32'(code_data), 32'h041);
        in_valid = 1'b1;
        rst = 1'b0;
        #1;
        check("midrst code_valid", 32'(code_valid), 32'd0);
        check("midrst code_data", 32'(code_data), 32'd0);
        check("midrst code_last", 32'(code_last), 32'd0);
        check("midrst in_ready", 32'(in_ready), 32'd0);
        check("midrst cam_en", 32'(cam_en), 32'd0);
        in_valid = 1'b0;
        rdy_mode = 0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rx.delete();
        bytes = '{8'h41, 8'h42};
        send_stream(bytes);
        want_q = '{10'h041, 10'h242};
        expect_codes("post-rst", want_q);

        // Random streams with throttling on both handshakes
        throttle = 1'b1;
        rdy_mode = 1;
        for (int s = 0; s < 6; s++) begin
            do_reset();
            bytes.delete();
            for (int i = 0; i < int'($urandom_range(1, 40)); i++)
                bytes.push_back(8'(8'h41 + $urandom_range(0, 2)));
            lzw_model(bytes, want_q);
            send_stream(bytes);
            expect_codes($sformatf("rand%0d", s), want_q);
        end
        throttle = 1'b0;
        rdy_mode = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
